// File: rtl/wormhole_allocator.sv
// Wormhole connection allocator: per-input IDLE/ESTABLISHED FSMs, per-output busy bit
// and round-robin pointer; a connection is held from header grant until its tail flit.
module wormhole_allocator #(
  parameter int PORTS = 4,
  parameter int DIR_W = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_i,
  input  logic [PORTS-1:0][DIR_W-1:0] req_dest_i,
  input  logic [PORTS-1:0]            tail_i,
  output logic [PORTS-1:0]            gnt_o,
  output logic [PORTS-1:0][DIR_W-1:0] gnt_dest_o,
  output logic [PORTS-1:0]            gnt_new_o,
  output logic [PORTS-1:0]            busy_o,
  output logic                        err_o
);

  typedef enum logic {IDLE, ESTABLISHED} state_t;

  state_t                      state [PORTS];
  logic [PORTS-1:0][DIR_W-1:0] ptr;
  logic [PORTS-1:0][PORTS-1:0] cand;
  logic [PORTS-1:0]            win_valid;
  logic [PORTS-1:0][DIR_W-1:0] win_idx;
  logic [DIR_W-1:0]            scan;
  logic                        dup_err;

  always_comb begin
    gnt_o = '0;
    for (int i = 0; i < PORTS; i++) begin
      gnt_o[i] = (state[i] == ESTABLISHED);
    end
  end

  // cand[j][i]: idle input i is presenting a header routed to output j
  always_comb begin
    cand = '0;
    for (int j = 0; j < PORTS; j++) begin
      for (int i = 0; i < PORTS; i++) begin
        cand[j][i] = (state[i] == IDLE) && req_i[i] && (req_dest_i[i] == DIR_W'(j));
      end
    end
  end

  // Round-robin search from ptr[j]; a busy output is not arbitrated, so a freed output waits one edge
  always_comb begin
    win_valid = '0;
    win_idx   = '0;
    scan      = '0;
    for (int j = 0; j < PORTS; j++) begin
      scan = ptr[j];
      for (int k = 0; k < PORTS; k++) begin
        if (!busy_o[j] && !win_valid[j] && cand[j][scan]) begin
          win_valid[j] = 1'b1;
          win_idx[j]   = scan;
        end
        scan = (scan == DIR_W'(PORTS-1)) ? '0 : scan + 1'b1;
      end
    end
  end

  always_comb begin
    dup_err = 1'b0;
    for (int a = 0; a < PORTS; a++) begin
      for (int b = a + 1; b < PORTS; b++) begin
        if (state[a] == ESTABLISHED && state[b] == ESTABLISHED &&
            gnt_dest_o[a] == gnt_dest_o[b]) begin
          dup_err = 1'b1;
        end
      end
    end
  end

  // Releases only touch established inputs and busy outputs, grants only idle inputs and free outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < PORTS; i++) begin
        state[i] <= IDLE;
      end
      gnt_dest_o <= '0;
      gnt_new_o  <= '0;
      busy_o     <= '0;
      ptr        <= '0;
      err_o      <= 1'b0;
    end else begin
      gnt_new_o <= '0;
      for (int i = 0; i < PORTS; i++) begin
        if (tail_i[i]) begin
          if (state[i] == ESTABLISHED) begin
            state[i]               <= IDLE;
            gnt_dest_o[i]          <= '0;
            busy_o[gnt_dest_o[i]]  <= 1'b0;
          end else begin
            err_o <= 1'b1;
          end
        end
      end
      for (int j = 0; j < PORTS; j++) begin
        if (win_valid[j]) begin
          state[win_idx[j]]      <= ESTABLISHED;
          gnt_dest_o[win_idx[j]] <= DIR_W'(j);
          gnt_new_o[win_idx[j]]  <= 1'b1;
          busy_o[j]              <= 1'b1;
          ptr[j]                 <= (win_idx[j] == DIR_W'(PORTS-1)) ? '0 : win_idx[j] + 1'b1;
        end
      end
      if (dup_err) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: doc/wormhole_allocator.md
WORMHOLE_ALLOCATOR -- requirements
Module: wormhole_allocator

Interface
REQ-001 The block SHALL have parameter PORTS, default 4, number of node input and output ports; legal range 2..8.
REQ-002 The block SHALL have parameter DIR_W, default $clog2(PORTS), width of a port index.
REQ-003 The block SHALL have clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have req_i  input  [PORTS] x 1  input i presents a HEADER flit with enable asserted.
REQ-006 The block SHALL have req_dest_i  input  [PORTS] x DIR_W  routed output port for input i's header; meaningful only while req_i[i]=1.
REQ-007 The block SHALL have tail_i  input  [PORTS] x 1  a TAIL flit on input i was transferred (enable and ack both high) this cycle.
REQ-008 The block SHALL have gnt_o  output  [PORTS] x 1  input i holds an established connection.
REQ-009 The block SHALL have gnt_dest_o  output  [PORTS] x DIR_W  output port held by input i; 0 when gnt_o[i]=0.
REQ-010 The block SHALL have gnt_new_o  output  [PORTS] x 1  one-cycle pulse in the first cycle gnt_o[i] is high.
REQ-011 The block SHALL have busy_o  output  [PORTS] x 1  output port j is allocated to some input.
REQ-012 The block SHALL have err_o  output  1  sticky protocol error flag.

Function
REQ-013 Each input SHALL run a two-state FSM: IDLE, ESTABLISHED; gnt_o[i] = (state == ESTABLISHED).
REQ-014 Each output j SHALL have a round-robin pointer ptr[j] (DIR_W bits) and a busy bit, busy_o[j].
REQ-015 In each cycle, candidates for output j SHALL be inputs in IDLE with req_i=1 and req_dest_i=j; arbitration SHALL take place only when registered busy_o[j]=0.
REQ-016 Winner SHALL be the first candidate found searching ptr[j], ptr[j]+1, ... modulo PORTS.
REQ-017 On a grant, at the next edge: winner goes ESTABLISHED, gnt_dest_o=j, gnt_new_o=1 for one cycle, busy_o[j]=1, ptr[j]=(winner+1) mod PORTS.
REQ-018 Latency: req_i asserted in cycle N with the output free -> gnt_o high in cycle N+1.
REQ-019 An input SHALL receive at most one grant per cycle; since it requests only one destination, this holds by construction; different outputs SHALL arbitrate independently and in parallel.
REQ-020 U-turn (req_dest_i[i]=i) SHALL be granted like any other destination.
REQ-021 ptr[j] SHALL change only on a grant for output j.
REQ-022 req_i from an ESTABLISHED input SHALL be ignored.
REQ-023 Release: tail_i[i]=1 while ESTABLISHED in cycle N -> in cycle N+1, gnt_o[i]=0, gnt_dest_o[i]=0, busy_o[gnt_dest_o[i]]=0.
REQ-024 A freed output SHALL NOT be re-granted at the same edge it is released; the earliest new gnt_o for that output is cycle N+2.
REQ-025 An input released at cycle N SHALL be eligible to request again from cycle N+1.
REQ-026 tail_i[i]=1 while IDLE SHALL be ignored for state and SHALL set err_o at the next edge.
REQ-027 If two ESTABLISHED inputs hold the same gnt_dest_o, err_o SHALL set; this is an internal invariant violation.
REQ-028 err_o SHALL remain set until reset.
REQ-029 Losing requesters SHALL wait without any timeout; RR ordering bounds the wait to PORTS-1 packets ahead of them.

Reset
REQ-030 rst=0 sampled at an edge SHALL force all FSMs to IDLE and set gnt_o, gnt_new_o, gnt_dest_o, busy_o, ptr[] and err_o to 0.
REQ-031 Reset mid-packet SHALL drop all connections without a release sequence; the first grant is possible in the cycle after rst returns to 1.
REQ-032 Inputs SHALL be ignored while rst=0.

Verification
REQ-033 Single request: after reset, req_i[1]=1, dest=2 at cycle 0 -> cycle 1: gnt_o[1]=1, gnt_dest_o[1]=2, gnt_new_o[1]=1, busy_o=4'b0100; cycle 2: gnt_new_o[1]=0.
REQ-034 Contention/RR: inputs 0, 1 and 3 all request dest 2 continuously, each releasing with tail one cycle after grant -> grant order 0,1,3,0,1,3; each grant is 3 cycles after the previous one.
REQ-035 Release/re-grant timing: input 0 holds output 3; input 2 requests 3; tail_i[0] at cycle 10 -> busy_o[3]=0 at cycle 11, gnt_o[2]=1 at cycle 12, busy_o[3]=1 at cycle 12.
REQ-036 Parallel outputs: in the same cycle, inputs 0->1, 1->0, 2->3, 3->2 -> all four gnt_o high in the next cycle, busy_o=4'b1111.
REQ-037 Protocol error: tail_i[2]=1 while input 2 is IDLE -> err_o=1 next cycle and it stays 1; no state change.
REQ-038 Reset mid-operation: with two connections established, rst=0 for one cycle -> all outputs 0; a pending request is granted one cycle after rst=1, with ptr reset to 0.
